// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter sequencing and instruction fetch for the SNACKS core,
// with start/done handshake and a saturating RUN-cycle counter.
module fetch_ctrl #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    start_addr,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               stall,
    input  logic               branch_take,
    input  logic [PC_W-1:0]    branch_off,
    input  logic               jump_take,
    input  logic [PC_W-1:0]    jump_target,
    input  logic               halt,
    output logic [PC_W-1:0]    pc,
    output logic               done,
    output logic [CNT_W-1:0]   cycle_count
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]      state;
    logic [PC_W-1:0] pc_next;

    // jump outranks branch; offset add wraps naturally in PC_W bits
    always_comb pc_next = jump_take ? jump_target : branch_take ? pc + branch_off : pc + PC_W'(1);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            cycle_count <= '0;
        end else if (state != RUN) begin
            if (start) begin
                state       <= RUN;
                pc          <= start_addr;
                cycle_count <= '0;
            end
        end else begin
            if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
            if (!stall) begin
                if (halt) state <= HALTED;
                else pc <= pc_next;
            end
        end
    end

    assign imem_addr   = pc;
    assign instr_valid = state == RUN;
    assign done        = state == HALTED;
    assign instr       = instr_valid ? imem_rdata : '0;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a behavioural model.
module tb_fetch_ctrl;
    logic       CLK = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0;
    logic       branch_take = 1'b0, jump_take = 1'b0, halt = 1'b0;
    logic [7:0] start_addr = '0, branch_off = '0, jump_target = '0;
    logic [7:0] imem_addr, pc, imem_addr_b, pc_b;
    logic [8:0] instr, instr_b, imem [256];
    logic       instr_valid, done, instr_valid_b, done_b;
    logic [15:0] cycle_count;
    logic [3:0]  cnt_b;
    int checks = 0, failures = 0;
    int m_st = 0, m_pc = 0, m_cnt = 0, m_cnt4 = 0;

    always #5 CLK = ~CLK;

    fetch_ctrl dut (
        .CLK(CLK), .reset(reset), .start(start), .start_addr(start_addr),
        .imem_addr(imem_addr), .imem_rdata(imem[imem_addr]), .instr(instr),
        .instr_valid(instr_valid), .stall(stall), .branch_take(branch_take),
        .branch_off(branch_off), .jump_take(jump_take), .jump_target(jump_target),
        .halt(halt), .pc(pc), .done(done), .cycle_count(cycle_count)
    );

    fetch_ctrl #(.CNT_W(4)) dut_b (
        .CLK(CLK), .reset(reset), .start(start), .start_addr(start_addr),
        .imem_addr(imem_addr_b), .imem_rdata(imem[imem_addr_b]), .instr(instr_b),
        .instr_valid(instr_valid_b), .stall(stall), .branch_take(branch_take),
        .branch_off(branch_off), .jump_take(jump_take), .jump_target(jump_target),
        .halt(halt), .pc(pc_b), .done(done_b), .cycle_count(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare();
        chk("pc", pc, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("valid", instr_valid, m_st == 1);
        chk("done", done, m_st == 2);
        chk("instr", instr, m_st == 1 ? imem[m_pc] : 9'h0);
        chk("cnt", cycle_count, m_cnt);
        chk("cnt4", cnt_b, m_cnt4);
        chk("pc_b", pc_b, m_pc);
    endtask

    // one clock: drive at posedge+1, compare at negedge, advance model at posedge
    task automatic step(input logic s, input logic [7:0] sa, input logic st, input logic bt,
                        input logic [7:0] bo, input logic jt, input logic [7:0] jtg, input logic h);
        start = s; start_addr = sa; stall = st; branch_take = bt;
        branch_off = bo; jump_take = jt; jump_target = jtg; halt = h;
        @(negedge CLK);
        compare();
        @(posedge CLK);
        if (m_st != 1) begin
            if (s) begin m_st = 1; m_pc = sa; m_cnt = 0; m_cnt4 = 0; end
        end else begin
            m_cnt = m_cnt < 65535 ? m_cnt + 1 : m_cnt;
            m_cnt4 = m_cnt4 < 15 ? m_cnt4 + 1 : m_cnt4;
            if (!st) begin
                if (h) m_st = 2;
                else if (jt) m_pc = jtg;
                else if (bt) m_pc = (m_pc + bo) % 256;
                else m_pc = (m_pc + 1) % 256;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 9'($urandom);
        #2;
        chk("rst_pc", pc, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_instr", instr, 0);
        chk("rst_cnt", cycle_count, 0);
        @(negedge CLK); reset = 1'b0;
        @(posedge CLK); #1;
        step(1, 8'h10, 0, 0, 8'h00, 0, 8'h00, 0);
        repeat (4) idle();
        chk("seq_cnt", cycle_count, 4);
        chk("seq_pc", pc, 8'h14);
        step(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1);
        step(1, 8'h20, 0, 0, 8'h00, 0, 8'h00, 0);
        step(0, 8'h00, 0, 1, 8'hFC, 0, 8'h00, 0);
        chk("branch_back", pc, 8'h1C);
        step(0, 8'h00, 0, 1, 8'h05, 1, 8'h40, 0);
        chk("jump_wins", pc, 8'h40);
        step(1, 8'h77, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("start_in_run", pc, 8'h41);
        step(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1);
        step(1, 8'hFF, 0, 0, 8'h00, 0, 8'h00, 0);
        idle();
        chk("wrap", pc, 8'h00);
        step(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1);
        step(1, 8'h05, 0, 0, 8'h00, 0, 8'h00, 0);
        repeat (3) step(0, 8'h00, 1, 0, 8'h00, 1, 8'h99, 1);
        chk("stall_pc", pc, 8'h05);
        chk("stall_cnt", cycle_count, 3);
        step(0, 8'h00, 0, 0, 8'h00, 1, 8'h08, 0);
        step(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1);
        chk("halt_done", done, 1);
        chk("halt_valid", instr_valid, 0);
        chk("halt_pc", pc, 8'h08);
        idle();
        chk("halt_hold", pc, 8'h08);
        step(1, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("restart_pc", pc, 8'h00);
        chk("restart_cnt", cycle_count, 0);
        chk("restart_done", done, 0);
        step(0, 8'h00, 0, 0, 8'h00, 1, 8'h33, 0);
        #2; reset = 1'b1; #1;
        chk("arst_pc", pc, 0);
        chk("arst_done", done, 0);
        chk("arst_valid", instr_valid, 0);
        chk("arst_cnt", cycle_count, 0);
        start = 1'b1; start_addr = 8'h44;
        @(posedge CLK); #1;
        chk("arst_start_pc", pc, 0);
        chk("arst_start_valid", instr_valid, 0);
        @(negedge CLK); reset = 1'b0; start = 1'b0;
        m_st = 0; m_pc = 0; m_cnt = 0; m_cnt4 = 0;
        @(posedge CLK); #1;
        step(1, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        repeat (20) idle();
        chk("sat4", cnt_b, 15);
        chk("cnt20", cycle_count, 20);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 5) == 0,
                 8'($urandom), $urandom_range(0, 19) == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
